// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate generator pipe.
// Holds the im_sel format encodings and the legal XLEN check.
package imm_gen_pipe_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    localparam int XLEN_LEGAL_32 = 32;
    localparam int XLEN_LEGAL_64 = 64;

    function automatic bit xlen_legal(int x);
        return (x == XLEN_LEGAL_32) || (x == XLEN_LEGAL_64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between producer, imm_gen_pipe and consumer.
// master: drives inst/im_sel/in_valid/out_ready; slave: the block.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [2:0]      im_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] im_out;
    logic            im_err;

    modport master (
        output in_valid, inst, im_sel, out_ready,
        input  in_ready, out_valid, im_out, im_err
    );

    modport slave (
        input  in_valid, inst, im_sel, out_ready,
        output in_ready, out_valid, im_out, im_err
    );
endinterface

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational RV32 immediate decode, sign/zero extended to XLEN.
// Ports: inst_i, im_sel_i in; imm_o, err_o (illegal select) out.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [2:0]      im_sel_i,
    output logic [XLEN-1:0] imm_o,
    output logic            err_o
);
    logic [31:0]            imm32;
    logic signed [XLEN-1:0] imm_ext;
    logic                   unused_opc;

    // Opcode bits never contribute to an immediate.
    assign unused_opc = ^inst_i[6:0];

    always_comb begin
        imm32 = '0;
        err_o = 1'b0;
        unique case (1'b1)
            (im_sel_i == IMM_I): imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            (im_sel_i == IMM_S): imm32 = {{20{inst_i[31]}}, inst_i[31:25],
                                          inst_i[11:7]};
            (im_sel_i == IMM_B): imm32 = {{19{inst_i[31]}}, inst_i[31],
                                          inst_i[7], inst_i[30:25],
                                          inst_i[11:8], 1'b0};
            (im_sel_i == IMM_U): imm32 = {inst_i[31:12], 12'b0};
            (im_sel_i == IMM_J): imm32 = {{11{inst_i[31]}}, inst_i[31],
                                          inst_i[19:12], inst_i[20],
                                          inst_i[30:21], 1'b0};
            (im_sel_i == IMM_Z): imm32 = {27'b0, inst_i[19:15]};
            default:             err_o = 1'b1;
        endcase
    end

    // Every 32-bit form already carries its sign in bit 31 (Z has 0 there),
    // so a single signed widening covers the XLEN=64 case.
    assign imm_ext = $signed(imm32);
    assign imm_o   = imm_ext;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry output buffer (OR + skid SR).
// Ports: clk, rst (async high), flush, bus (slave handshake bundle).
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    imm_gen_pipe_if.slave bus
);
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] or_imm_q, sr_imm_q;
    logic            or_err_q, sr_err_q;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    logic            accept;
    logic            or_load, or_from_sr, sr_load;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst_i   (bus.inst),
        .im_sel_i (bus.im_sel),
        .imm_o    (dec_imm),
        .err_o    (dec_err)
    );

    // Ready depends only on state, never on out_ready.
    assign bus.in_ready  = (state_q != ST_FULL);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.im_out    = or_imm_q;
    assign bus.im_err    = or_err_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        or_load    = 1'b0;
        or_from_sr = 1'b0;
        sr_load    = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        or_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && bus.out_ready) begin
                        or_load = 1'b1;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        sr_load = 1'b1;
                    end else if (bus.out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        state_d    = ST_ONE;
                        or_from_sr = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            or_imm_q <= '0;
            or_err_q <= 1'b0;
            sr_imm_q <= '0;
            sr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (or_load) begin
                or_imm_q <= dec_imm;
                or_err_q <= dec_err;
            end else if (or_from_sr) begin
                or_imm_q <= sr_imm_q;
                or_err_q <= sr_err_q;
            end
            if (sr_load) begin
                sr_imm_q <= dec_imm;
                sr_err_q <= dec_err;
            end
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, meaning output immediate width; the only legal values SHALL be 32 and 64.
REQ-002 clk  input  1  single clock; all state on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 flush  input  1  synchronous; discards all buffered entries.
REQ-005 in_valid  input  1  inst/im_sel are valid this cycle.
REQ-006 in_ready  output  1  block can accept; registered, not combinational on out_ready.
REQ-007 inst  input  32  RV32 instruction word.
REQ-008 im_sel  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR uimm), 110/111 illegal.
REQ-009 out_valid  output  1  im_out/im_err are valid.
REQ-010 out_ready  input  1  consumer accepts this cycle.
REQ-011 im_out  output  XLEN  generated immediate.
REQ-012 im_err  output  1  entry came from an illegal im_sel.

Function
REQ-013 I format SHALL be sign-extended inst[31:20].
REQ-014 S format SHALL be sign-extended {inst[31:25], inst[11:7]}.
REQ-015 B format SHALL be sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
REQ-016 U format SHALL be {inst[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
REQ-017 J format SHALL be sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
REQ-018 Z format SHALL be zero-extended inst[19:15].
REQ-019 Illegal im_sel SHALL give im_out = 0 and im_err = 1; all legal formats give im_err = 0.
REQ-020 Decode SHALL be combinational, with the result captured in a 2-entry buffer (output register OR plus skid register SR).
REQ-021 A transfer SHALL occur on in_valid && in_ready; output handoff SHALL occur on out_valid && out_ready.
REQ-022 Latency from accepted input to out_valid SHALL be exactly 1 cycle when OR is empty or draining.
REQ-023 Buffer states: EMPTY (OR and SR invalid), ONE (OR valid), FULL (OR and SR valid).
REQ-024 EMPTY + accept -> ONE.
REQ-025 ONE + accept + out_ready -> ONE, with OR reloaded.
REQ-026 ONE + accept + !out_ready -> FULL, with new entry in SR.
REQ-027 ONE + no accept + out_ready -> EMPTY.
REQ-028 FULL + out_ready -> ONE, with SR moved to OR; no accept is possible in FULL.
REQ-029 in_ready SHALL equal !SR_valid, giving full throughput of one entry per cycle with no bubble.
REQ-030 out_valid SHALL equal OR_valid; im_out/im_err SHALL hold stable while out_valid && !out_ready.
REQ-031 flush SHALL force EMPTY next cycle and take priority over a simultaneous accept, which is dropped.
REQ-032 Data registers SHALL load only on capture; when invalid their values are don't-care and not checked.

Reset
REQ-033 rst SHALL clear OR_valid and SR_valid immediately (out_valid = 0, in_ready = 1).
REQ-034 rst SHALL clear im_out and im_err to 0.
REQ-035 Reset asserted mid-transfer SHALL discard both entries; the first accept after deassertion behaves as from EMPTY.

Structure
REQ-036 A shared package SHALL hold the im_sel encodings (IMM_I..IMM_Z) and the XLEN legal-value check constant.
REQ-037 One sub-module, imm_decode, SHALL hold the combinational format decode, parametrised by XLEN.
REQ-038 The top level SHALL hold only the buffer/handshake logic.

Verification
REQ-039 I/S decode: inst 0xFFF00093 with I -> 0xFFFFFFFF; inst 0x00112623 with S -> 0x0000000C; 1-cycle latency; out_ready held high.
REQ-040 B/U/J decode: 0xFE000CE3 with B -> 0xFFFFFFF8; 0x123450B7 with U -> 0x12345000; 0xFFDFF0EF with J -> 0xFFFFFFFC; with XLEN=64 the same J -> 0xFFFFFFFFFFFFFFFC.
REQ-041 Backpressure: out_ready = 0 with 3 back-to-back inputs -> exactly 2 accepted, in_ready low in cycle 3, im_out stable; then out_ready = 1 -> both drain in order on consecutive cycles.
REQ-042 Illegal select: im_sel = 111, any inst -> im_out = 0, im_err = 1; next Z entry with inst[19:15] = 5'h1F -> 0x1F, im_err = 0.
REQ-043 Flush with reset: FULL state plus flush together with in_valid -> EMPTY next cycle, nothing emitted. Async rst pulsed between clock edges while ONE -> out_valid = 0 immediately.
